// File: rtl/tjmono_hit_pkg.sv
// Shared definitions for the TJ-Monopix hit assembler.
// Holds the word tag constants, record field widths and bit offsets,
// the assembler state enum, and small helpers used by the top level.
package tjmono_hit_pkg;

  // Upstream word layout
  localparam int WORD_W    = 32;
  localparam int ID_W      = 2;
  localparam int TAG_W     = 2;
  localparam int PAYLOAD_W = 28;
  localparam int ID_LSB    = 30;
  localparam int TAG_LSB   = 28;

  // Word tags: each carries one 28-bit slice of the record
  localparam logic [TAG_W-1:0] TAG_WORD0 = 2'b00;
  localparam logic [TAG_W-1:0] TAG_WORD1 = 2'b01;
  localparam logic [TAG_W-1:0] TAG_WORD2 = 2'b10;
  localparam logic [TAG_W-1:0] TAG_ILLEGAL = 2'b11;

  // Record slice offsets
  localparam int REC_W      = 84;
  localparam int SLICE0_LSB = 0;
  localparam int SLICE1_LSB = 28;
  localparam int SLICE2_LSB = 56;

  // Record field widths
  localparam int COL_W   = 6;
  localparam int ROW_W   = 9;
  localparam int TE_W    = 6;
  localparam int LE_W    = 6;
  localparam int TS_W    = 52;
  localparam int TOKEN_W = 4;
  localparam int TOT_W   = 6;

  // Record field offsets
  localparam int COL_LSB   = 0;
  localparam int ROW_LSB   = 6;
  localparam int TE_LSB    = 15;
  localparam int LE_LSB    = 21;
  localparam int NOISE_BIT = 27;
  localparam int TS_LSB    = 28;
  localparam int TOKEN_LSB = 80;

  // Counter widths
  localparam int ERR_CNT_W = 8;
  localparam int HIT_CNT_W = 32;

  // W0/W1/W2 wait for the word with tag 00/01/10; OUT holds a finished hit
  typedef enum logic [1:0] {
    ST_W0  = 2'd0,
    ST_W1  = 2'd1,
    ST_W2  = 2'd2,
    ST_OUT = 2'd3
  } state_t;

  // Tag the assembler expects while in a given state. OUT never evaluates
  // a word, so it maps to the tag that can never match.
  function automatic logic [TAG_W-1:0] expected_tag(input state_t st);
    case (st)
      ST_W0:   expected_tag = TAG_WORD0;
      ST_W1:   expected_tag = TAG_WORD1;
      ST_W2:   expected_tag = TAG_WORD2;
      default: expected_tag = TAG_ILLEGAL;
    endcase
  endfunction

  // Time over threshold: trailing edge minus leading edge, modulo 64
  function automatic logic [TOT_W-1:0] calc_tot(input logic [TE_W-1:0] te,
                                                 input logic [LE_W-1:0] le);
    calc_tot = te - le;
  endfunction

endpackage

// File: rtl/tjmono_hit_assembler.sv
// Assembles three tagged 32-bit FIFO words into one 84-bit hit record.
// Latency: first FIFO_READ at cycle 0 -> HIT_VALID at cycle 6; one hit per 7 cycles at best.
// Backpressure: holds the hit stable in OUT and issues no FIFO_READ until HIT_READY.
//
// Optional feature: define TJMONO_HIT_TOT_EN to add the registered HIT_TOT output.
//
// Ports:
//   BUS_CLK, RST           clock, synchronous active-high reset
//   FIFO_EMPTY, FIFO_DATA  upstream word FIFO (data valid the cycle after FIFO_READ)
//   FIFO_READ              single-cycle pop request
//   HIT_VALID, HIT_READY   downstream valid/ready handshake
//   HIT_COL..HIT_TOKEN     decoded record fields (HIT_TOT when enabled)
//   SEQ_ERR_CNT            saturating count of tag-sequence errors
//   ID_ERR_CNT             saturating count of identifier mismatches
//   HIT_CNT                wrapping count of hits accepted downstream
module tjmono_hit_assembler
  import tjmono_hit_pkg::*;
#(
  parameter logic [1:0] IDENTIFIER = 2'b00
) (
  input  logic                  BUS_CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic [WORD_W-1:0]     FIFO_DATA,
  output logic                  FIFO_READ,
  output logic                  HIT_VALID,
  input  logic                  HIT_READY,
  output logic [COL_W-1:0]      HIT_COL,
  output logic [ROW_W-1:0]      HIT_ROW,
  output logic [TE_W-1:0]       HIT_TE,
  output logic [LE_W-1:0]       HIT_LE,
  output logic                  HIT_NOISE,
  output logic [TS_W-1:0]       HIT_TS,
  output logic [TOKEN_W-1:0]    HIT_TOKEN,
  output logic [ERR_CNT_W-1:0]  SEQ_ERR_CNT,
  output logic [ERR_CNT_W-1:0]  ID_ERR_CNT,
  output logic [HIT_CNT_W-1:0]  HIT_CNT
`ifdef TJMONO_HIT_TOT_EN
  ,
  output logic [TOT_W-1:0]      HIT_TOT
`endif
);

  state_t                 state;
  state_t                 state_nxt;
  logic                   pending;
  logic [REC_W-1:0]       rec;
  logic [ERR_CNT_W-1:0]   seq_err_cnt;
  logic [ERR_CNT_W-1:0]   id_err_cnt;
  logic [HIT_CNT_W-1:0]   hit_cnt;

  // Fields of the word being evaluated
  logic [ID_W-1:0]        word_id;
  logic [TAG_W-1:0]       word_tag;
  logic [PAYLOAD_W-1:0]   word_payload;

  // Evaluation outcomes; at most one is high, and only while pending
  logic                   word_id_err;
  logic                   word_store;
  logic                   word_restart;
  logic                   word_drop;
  logic                   seq_err;

  assign word_id      = FIFO_DATA[ID_LSB +: ID_W];
  assign word_tag     = FIFO_DATA[TAG_LSB +: TAG_W];
  assign word_payload = FIFO_DATA[PAYLOAD_W-1:0];

  // A word is only looked at in the cycle right after its pop. The identifier
  // check comes first so a foreign word never disturbs the sequence.
  always_comb begin
    word_id_err  = 1'b0;
    word_store   = 1'b0;
    word_restart = 1'b0;
    word_drop    = 1'b0;
    if (pending) begin
      if (word_id != IDENTIFIER) begin
        word_id_err = 1'b1;
      end else if (word_tag == expected_tag(state)) begin
        word_store = 1'b1;
      end else if (word_tag == TAG_WORD0) begin
        // A fresh word 0 mid-record starts a new record instead of being lost
        word_restart = 1'b1;
      end else begin
        word_drop = 1'b1;
      end
    end
  end

  assign seq_err = word_restart | word_drop;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state <= ST_W0;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_W0, ST_W1, ST_W2: begin
        if (word_store) begin
          case (state)
            ST_W0:   state_nxt = ST_W1;
            ST_W1:   state_nxt = ST_W2;
            default: state_nxt = ST_OUT;
          endcase
        end else if (word_restart) begin
          state_nxt = ST_W1;
        end else if (word_drop) begin
          state_nxt = ST_W0;
        end
      end
      ST_OUT: begin
        if (HIT_READY) begin
          state_nxt = ST_W0;
        end
      end
      default: state_nxt = ST_W0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Reads alternate with evaluation cycles, so only one word is ever in flight.
  // RST gates the pop so nothing leaves the upstream FIFO during reset.
  always_comb begin
    FIFO_READ = 1'b0;
    HIT_VALID = 1'b0;
    case (state)
      ST_OUT:  HIT_VALID = 1'b1;
      default: FIFO_READ = !RST && !FIFO_EMPTY && !pending;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read tracking: pending marks the cycle FIFO_DATA holds the popped word
  // ---------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      pending <= 1'b0;
    end else begin
      pending <= FIFO_READ;
    end
  end

  // ---------------------------------------------------------------------------
  // Record assembly. The record is untouched in OUT (no reads happen there),
  // which keeps the HIT_* outputs stable while waiting for HIT_READY.
  // ---------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      rec <= '0;
    end else if (word_store) begin
      case (state)
        ST_W0:   rec[SLICE0_LSB +: PAYLOAD_W] <= word_payload;
        ST_W1:   rec[SLICE1_LSB +: PAYLOAD_W] <= word_payload;
        default: rec[SLICE2_LSB +: PAYLOAD_W] <= word_payload;
      endcase
    end else if (word_restart) begin
      rec[SLICE0_LSB +: PAYLOAD_W] <= word_payload;
    end
  end

`ifdef TJMONO_HIT_TOT_EN
  // te and le both live in slice 0, already stored by the time word 2 lands,
  // so TOT is captured on the same edge that enters OUT.
  logic [TOT_W-1:0] tot;

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      tot <= '0;
    end else if (word_store && state == ST_W2) begin
      tot <= calc_tot(rec[TE_LSB +: TE_W], rec[LE_LSB +: LE_W]);
    end
  end

  assign HIT_TOT = tot;
`endif

  // ---------------------------------------------------------------------------
  // Counters: error counters stop at all-ones, the hit counter wraps
  // ---------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      seq_err_cnt <= '0;
    end else if (seq_err && seq_err_cnt != {ERR_CNT_W{1'b1}}) begin
      seq_err_cnt <= seq_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      id_err_cnt <= '0;
    end else if (word_id_err && id_err_cnt != {ERR_CNT_W{1'b1}}) begin
      id_err_cnt <= id_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      hit_cnt <= '0;
    end else if (HIT_VALID && HIT_READY) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Field decode
  // ---------------------------------------------------------------------------
  assign HIT_COL     = rec[COL_LSB +: COL_W];
  assign HIT_ROW     = rec[ROW_LSB +: ROW_W];
  assign HIT_TE      = rec[TE_LSB +: TE_W];
  assign HIT_LE      = rec[LE_LSB +: LE_W];
  assign HIT_NOISE   = rec[NOISE_BIT];
  assign HIT_TS      = rec[TS_LSB +: TS_W];
  assign HIT_TOKEN   = rec[TOKEN_LSB +: TOKEN_W];
  assign SEQ_ERR_CNT = seq_err_cnt;
  assign ID_ERR_CNT  = id_err_cnt;
  assign HIT_CNT     = hit_cnt;

endmodule

// File: tb/tb_tjmono_hit_assembler.sv
// Testbench for tjmono_hit_assembler: upstream FIFO model, downstream
// monitor, vector table, hand-written corner sequences and a randomized
// word stream checked against a word-level reference model.
module tb_tjmono_hit_assembler;

  logic        BUS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_EMPTY = 1'b1;
  logic [31:0] FIFO_DATA = '0;
  logic        FIFO_READ;
  logic        HIT_VALID;
  logic        HIT_READY = 1'b0;
  logic [5:0]  HIT_COL;
  logic [8:0]  HIT_ROW;
  logic [5:0]  HIT_TE;
  logic [5:0]  HIT_LE;
  logic        HIT_NOISE;
  logic [51:0] HIT_TS;
  logic [3:0]  HIT_TOKEN;
  logic [7:0]  SEQ_ERR_CNT;
  logic [7:0]  ID_ERR_CNT;
  logic [31:0] HIT_CNT;
`ifdef TJMONO_HIT_TOT_EN
  logic [5:0]  HIT_TOT;
`endif

  tjmono_hit_assembler #(.IDENTIFIER(2'b00)) dut (
    .BUS_CLK     (BUS_CLK),
    .RST         (RST),
    .FIFO_EMPTY  (FIFO_EMPTY),
    .FIFO_DATA   (FIFO_DATA),
    .FIFO_READ   (FIFO_READ),
    .HIT_VALID   (HIT_VALID),
    .HIT_READY   (HIT_READY),
    .HIT_COL     (HIT_COL),
    .HIT_ROW     (HIT_ROW),
    .HIT_TE      (HIT_TE),
    .HIT_LE      (HIT_LE),
    .HIT_NOISE   (HIT_NOISE),
    .HIT_TS      (HIT_TS),
    .HIT_TOKEN   (HIT_TOKEN),
    .SEQ_ERR_CNT (SEQ_ERR_CNT),
    .ID_ERR_CNT  (ID_ERR_CNT),
    .HIT_CNT     (HIT_CNT)
`ifdef TJMONO_HIT_TOT_EN
    ,
    .HIT_TOT     (HIT_TOT)
`endif
  );

  initial forever #5 BUS_CLK = ~BUS_CLK;

  typedef struct {
    logic [83:0] rec;
    logic [5:0]  tot;
  } hit_t;

  typedef struct {
    logic [31:0] w [5];
    int          n;
    int          hits;
    int          seq;
    int          id;
    logic [83:0] rec;
    logic [5:0]  tot;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo_q [$];
  hit_t        got_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [83:0] mk_rec(input logic [5:0] col, input logic [8:0] row,
                                         input logic [5:0] te, input logic [5:0] le,
                                         input logic noise, input logic [51:0] ts,
                                         input logic [3:0] token);
    return {token, ts, noise, le, te, row, col};
  endfunction

  function automatic logic [31:0] wd(input logic [83:0] r, input int k);
    logic [27:0] p;
    p = r[k*28 +: 28];
    return {2'b00, 2'(k), p};
  endfunction

  function automatic logic [5:0] tot_of(input logic [83:0] r);
    return 6'((int'(r[20:15]) - int'(r[26:21]) + 64) % 64);
  endfunction

  function automatic hit_t sample_hit();
    hit_t h;
    h.rec = {HIT_TOKEN, HIT_TS, HIT_NOISE, HIT_LE, HIT_TE, HIT_ROW, HIT_COL};
`ifdef TJMONO_HIT_TOT_EN
    h.tot = HIT_TOT;
`else
    h.tot = '0;
`endif
    return h;
  endfunction

  task automatic push_rec(input logic [83:0] r);
    for (int k = 0; k < 3; k++) fifo_q.push_back(wd(r, k));
  endtask

  // Main-thread time base: 2 units after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge BUS_CLK);
      #2;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  // Runs until the FIFO is empty and no hit is held for 8 cycles
  task automatic drain(input string name, input int budget);
    int idle = 0;
    for (int i = 0; i < budget && idle < 8; i++) begin
      tick(1);
      if (fifo_q.size() == 0 && !HIT_VALID) idle++;
      else idle = 0;
    end
    check({name, "_drain_timeout"}, idle >= 8, 1);
  endtask

  // Upstream FIFO: a pop requested in one cycle presents the word 1 unit
  // after the following rising edge, i.e. during the evaluation cycle.
  initial begin : fifo_model
    logic rd;
    forever begin
      @(negedge BUS_CLK);
      rd = FIFO_READ;
      @(posedge BUS_CLK);
      #1;
      if (rd) begin
        check("fifo_underflow", fifo_q.size() > 0, 1);
        if (fifo_q.size() > 0) FIFO_DATA = fifo_q.pop_front();
      end
      FIFO_EMPTY = (fifo_q.size() == 0);
    end
  end

  // Downstream monitor: collects accepted hits, checks hold stability and
  // that nothing is popped while a hit is presented.
  initial begin : monitor
    logic prev_hold;
    hit_t prev;
    hit_t cur;
    prev_hold = 1'b0;
    forever begin
      @(negedge BUS_CLK);
      cur = sample_hit();
      if (prev_hold && !RST) begin
        check("hold_valid", HIT_VALID, 1);
        check("hold_rec", cur.rec, prev.rec);
        check("hold_tot", cur.tot, prev.tot);
      end
      if (HIT_VALID) check("read_in_out", FIFO_READ, 0);
      if (HIT_VALID && HIT_READY && !RST) got_q.push_back(cur);
      prev_hold = HIT_VALID && !HIT_READY && !RST;
      prev = cur;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl [7];
    logic [83:0] r1, r2, r3;
    int          c_rd, c_v1, c_v2;
    logic        prev_v;
    hit_t        exp_q [$];
    logic [31:0] stream [$];
    int          mseq, mid, need;
    logic [27:0] parts [3];
    int          wait_ok;

    r1 = mk_rec(6'd5, 9'd300, 6'd20, 6'd10, 1'b0, 52'h123, 4'h0);
    r2 = mk_rec(6'h3f, 9'h1ab, 6'd4, 6'd60, 1'b1, 52'hfedcba9876543, 4'ha);
    r3 = mk_rec(6'd1, 9'd2, 6'd3, 6'd4, 1'b0, 52'h1, 4'h5);

    tbl[0].w = '{wd(r1,0), wd(r1,1), wd(r1,2), 0, 0};
    tbl[0].n = 3; tbl[0].hits = 1; tbl[0].seq = 0; tbl[0].id = 0; tbl[0].rec = r1; tbl[0].tot = 6'd10;
    tbl[1].w = '{wd(r2,0), wd(r2,1), wd(r2,2), 0, 0};
    tbl[1].n = 3; tbl[1].hits = 1; tbl[1].seq = 0; tbl[1].id = 0; tbl[1].rec = r2; tbl[1].tot = 6'd8;
    tbl[2].w = '{wd(r3,0), wd(r3,2), wd(r1,0), wd(r1,1), wd(r1,2)};
    tbl[2].n = 5; tbl[2].hits = 1; tbl[2].seq = 1; tbl[2].id = 0; tbl[2].rec = r1; tbl[2].tot = 6'd10;
    tbl[3].w = '{wd(r3,0), wd(r2,0), wd(r2,1), wd(r2,2), 0};
    tbl[3].n = 4; tbl[3].hits = 1; tbl[3].seq = 1; tbl[3].id = 0; tbl[3].rec = r2; tbl[3].tot = 6'd8;
    tbl[4].w = '{wd(r1,0), 32'hDFFF_FFFF, wd(r1,1), wd(r1,2), 0};
    tbl[4].n = 4; tbl[4].hits = 1; tbl[4].seq = 0; tbl[4].id = 1; tbl[4].rec = r1; tbl[4].tot = 6'd10;
    tbl[5].w = '{32'h3000_0000, wd(r3,0), wd(r3,1), wd(r3,2), 0};
    tbl[5].n = 4; tbl[5].hits = 1; tbl[5].seq = 1; tbl[5].id = 0; tbl[5].rec = r3; tbl[5].tot = 6'd63;
    tbl[6].w = '{wd(r1,0), wd(r1,1), wd(r2,1), 0, 0};
    tbl[6].n = 3; tbl[6].hits = 0; tbl[6].seq = 1; tbl[6].id = 0; tbl[6].rec = '0; tbl[6].tot = '0;

    // Reset state, with a word waiting upstream to prove reads are gated
    fifo_q.push_back(32'hC000_0000);
    tick(3);
    check("rst_fifo_read", FIFO_READ, 0);
    check("rst_fifo_empty_seen", FIFO_EMPTY, 0);
    check("rst_hit_valid", HIT_VALID, 0);
    check("rst_fields", sample_hit().rec, 0);
    check("rst_counters", {SEQ_ERR_CNT, ID_ERR_CNT, HIT_CNT}, 0);
    RST = 1'b0;
    tick(6);
    check("post_rst_word_consumed", ID_ERR_CNT, 1);

    // Vector table
    HIT_READY = 1'b1;
    for (int v = 0; v < 7; v++) begin
      do_reset();
      got_q.delete();
      for (int k = 0; k < tbl[v].n; k++) fifo_q.push_back(tbl[v].w[k]);
      drain($sformatf("vec%0d", v), 500);
      check($sformatf("vec%0d_hits", v), got_q.size(), tbl[v].hits);
      check($sformatf("vec%0d_hit_cnt", v), HIT_CNT, tbl[v].hits);
      check($sformatf("vec%0d_seq_err", v), SEQ_ERR_CNT, tbl[v].seq);
      check($sformatf("vec%0d_id_err", v), ID_ERR_CNT, tbl[v].id);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_rec", v), got_q[got_q.size()-1].rec, tbl[v].rec);
`ifdef TJMONO_HIT_TOT_EN
        check($sformatf("vec%0d_tot", v), got_q[got_q.size()-1].tot, tbl[v].tot);
`endif
      end
    end

    // Latency and sustained rate
    do_reset();
    got_q.delete();
    HIT_READY = 1'b1;
    push_rec(r1);
    push_rec(r2);
    c_rd = -1; c_v1 = -1; c_v2 = -1; prev_v = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (FIFO_READ && c_rd < 0) c_rd = c;
      if (HIT_VALID && !prev_v) begin
        if (c_v1 < 0) c_v1 = c;
        else if (c_v2 < 0) c_v2 = c;
      end
      prev_v = HIT_VALID;
    end
    check("latency_first_hit", c_v1 - c_rd, 6);
    check("hit_period", c_v2 - c_v1, 7);
    check("latency_hits", got_q.size(), 2);

    // Backpressure hold, then reset from W2
    do_reset();
    got_q.delete();
    HIT_READY = 1'b0;
    push_rec(r1);
    wait_ok = 0;
    for (int c = 0; c < 50 && !wait_ok; c++) begin
      tick(1);
      if (HIT_VALID) wait_ok = 1;
    end
    check("hold_reached_out", wait_ok, 1);
    fifo_q.push_back(32'hC000_0000);
    fifo_q.push_back(wd(r2, 0));
    fifo_q.push_back(wd(r2, 1));
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("hold_no_read", FIFO_READ, 0);
      check("hold_fields_r1", sample_hit().rec, r1);
    end
    check("hold_hit_cnt", HIT_CNT, 0);
    HIT_READY = 1'b1;
    tick(1);
    HIT_READY = 1'b0;
    check("accept_hit_cnt", HIT_CNT, 1);
    check("accept_rec", got_q.size() == 1 ? got_q[0].rec : '0, r1);
    tick(12);
    check("w2_id_err", ID_ERR_CNT, 1);
    check("w2_no_hit", HIT_VALID, 0);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check("rst_w2_counters", {SEQ_ERR_CNT, ID_ERR_CNT, HIT_CNT}, 0);
    check("rst_w2_valid", HIT_VALID, 0);
    check("rst_w2_fields", sample_hit().rec, 0);
    got_q.delete();
    HIT_READY = 1'b1;
    push_rec(r3);
    drain("after_rst", 200);
    check("after_rst_seq_err", SEQ_ERR_CNT, 0);
    check("after_rst_hits", got_q.size(), 1);
    if (got_q.size() > 0) check("after_rst_rec", got_q[0].rec, r3);

    // Saturation of both error counters
    do_reset();
    for (int k = 0; k < 260; k++) fifo_q.push_back(32'hC000_0000);
    drain("id_sat", 2000);
    check("id_err_saturate", ID_ERR_CNT, 255);
    for (int k = 0; k < 260; k++) fifo_q.push_back(32'h3000_0000);
    drain("seq_sat", 2000);
    check("seq_err_saturate", SEQ_ERR_CNT, 255);
    check("sat_id_held", ID_ERR_CNT, 255);

    // Randomized stream against a word-level model
    do_reset();
    got_q.delete();
    for (int h = 0; h < 120; h++) begin
      logic [95:0] rnd;
      rnd = {$urandom, $urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 7) == 0) stream.push_back($urandom);
        stream.push_back(wd(rnd[83:0], k));
      end
    end
    mseq = 0; mid = 0; need = 0;
    foreach (stream[i]) begin
      logic [31:0] w;
      w = stream[i];
      if (w[31:30] != 2'b00) begin
        mid++;
      end else if (int'(w[29:28]) == need) begin
        parts[need] = w[27:0];
        need++;
        if (need == 3) begin
          hit_t e;
          e.rec = {parts[2], parts[1], parts[0]};
          e.tot = tot_of(e.rec);
          exp_q.push_back(e);
          need = 0;
        end
      end else if (w[29:28] == 2'b00) begin
        mseq++;
        parts[0] = w[27:0];
        need = 1;
      end else begin
        mseq++;
        need = 0;
      end
      fifo_q.push_back(w);
    end
    wait_ok = 0;
    for (int c = 0; c < 20000 && !wait_ok; c++) begin
      HIT_READY = ($urandom_range(0, 3) != 0);
      tick(1);
      if (fifo_q.size() == 0 && got_q.size() >= exp_q.size()) wait_ok = 1;
    end
    HIT_READY = 1'b1;
    tick(8);
    check("rand_timeout", wait_ok, 1);
    check("rand_hit_count", got_q.size(), exp_q.size());
    check("rand_hit_cnt", HIT_CNT, exp_q.size());
    check("rand_seq_err", SEQ_ERR_CNT, mseq > 255 ? 255 : mseq);
    check("rand_id_err", ID_ERR_CNT, mid > 255 ? 255 : mid);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("rand_rec%0d", i), got_q[i].rec, exp_q[i].rec);
`ifdef TJMONO_HIT_TOT_EN
      check($sformatf("rand_tot%0d", i), got_q[i].tot, exp_q[i].tot);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tjmono_hit_assembler.md
TJMONO_HIT_ASSEMBLER -- requirements
Module: tjmono_hit_assembler

Interface
REQ-001 Parameter IDENTIFIER, default 2'b00: value expected in FIFO_DATA[31:30].
REQ-002 BUS_CLK  input  1  sole clock; all logic on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 FIFO_EMPTY  input  1  upstream word FIFO is empty.
REQ-005 FIFO_DATA  input  32  upstream word: [31:30] identifier, [29:28] tag, [27:0] payload; valid the cycle after FIFO_READ.
REQ-006 FIFO_READ  output  1  single-cycle pop request to the upstream FIFO.
REQ-007 HIT_VALID  output  1  assembled hit present on HIT_* outputs.
REQ-008 HIT_READY  input  1  downstream accepts the hit when HIT_VALID and HIT_READY are both high.
REQ-009 HIT_COL 6, HIT_ROW 9, HIT_TE 6, HIT_LE 6, HIT_NOISE 1, HIT_TS 52, HIT_TOKEN 4  outputs  decoded record fields.
REQ-010 HIT_TOT  output  6  time over threshold; present only when TJMONO_HIT_TOT_EN is defined.
REQ-011 SEQ_ERR_CNT  output  8  tag-sequence error counter.
REQ-012 ID_ERR_CNT  output  8  identifier-mismatch counter.
REQ-013 HIT_CNT  output  32  count of hits accepted downstream.

Function
REQ-014 Record layout (84 b): [5:0] col, [14:6] row, [20:15] te, [26:21] le, [27] noise, [79:28] ts, [83:80] token.
REQ-015 Word order and tags: tag 00 carries record[27:0], tag 01 carries record[55:28], tag 10 carries record[83:56]; tag 11 is always illegal.
REQ-016 States: W0, W1, W2 (expecting tag 00/01/10) and OUT (holding a hit).
REQ-017 In W0/W1/W2, FIFO_READ is high iff FIFO_EMPTY is low and no read is pending; pending is set for exactly the cycle after FIFO_READ, and that cycle evaluates the word.
REQ-018 Identifier mismatch: word discarded, ID_ERR_CNT +1, state unchanged.
REQ-019 Expected tag: payload stored into its slice; W0->W1, W1->W2, W2->OUT.
REQ-020 Unexpected tag, non-00: partial record dropped, SEQ_ERR_CNT +1, next state W0.
REQ-021 Unexpected tag 00 while in W1 or W2: SEQ_ERR_CNT +1, word stored as new word 0, next state W1.
REQ-022 HIT_VALID equals (state==OUT); HIT_* outputs are stable while HIT_VALID is high and HIT_READY is low.
REQ-023 Handshake in OUT: HIT_READY high -> HIT_CNT +1, next state W0; no FIFO_READ is issued in OUT.
REQ-024 Latency with a non-empty FIFO: first FIFO_READ at cycle 0 -> HIT_VALID at cycle 6; sustained rate is one hit per 7 cycles with HIT_READY tied high.
REQ-025 SEQ_ERR_CNT and ID_ERR_CNT saturate at 255; HIT_CNT wraps at 2^32.

Reset
REQ-026 RST -> state W0, pending 0, FIFO_READ 0, HIT_VALID 0, all HIT_* fields 0, all counters 0.
REQ-027 RST asserted mid-record or in OUT abandons the record without counting an error; a read outstanding during RST is discarded.

Configuration
REQ-028 Macro TJMONO_HIT_TOT_EN defined: HIT_TOT = (te - le) mod 64, registered with the record and valid with HIT_VALID.
REQ-029 TJMONO_HIT_TOT_EN undefined: HIT_TOT port and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package tjmono_hit_pkg holds the tag constants, the field widths and bit offsets, and the state enum.
REQ-031 The block has no sub-module; the saturating 8-bit counter is written inline twice.

Verification
REQ-032 Words 00/01/10 with record col=5, row=300, te=20, le=10, ts=0x123 -> HIT_VALID at cycle 6 with those fields; HIT_TOT=10 when enabled.
REQ-033 le=60, te=4 with TJMONO_HIT_TOT_EN defined -> HIT_TOT=8 (wrap-around).
REQ-034 Sequence 00, 10 -> SEQ_ERR_CNT=1, no hit; following 00/01/10 -> one correct hit.
REQ-035 Sequence 00, 00, 01, 10 -> SEQ_ERR_CNT=1, one hit built from the second 00.
REQ-036 Word carrying identifier 2'b11 between tags 00 and 01 -> ID_ERR_CNT=1, hit still assembled correctly.
REQ-037 HIT_READY held low 20 cycles in OUT -> no FIFO_READ, outputs stable; HIT_READY high -> HIT_CNT=1; RST in W2 -> W0 with all counters 0.
